path_hop_streamer: RTL

- Consumes the packed path result of pl_riscv_cpu (path0..path8, path_found) and replays it as a stream of node IDs.
- Snapshots all path words on the rising edge of path_found, then emits one hop per valid/ready handshake.
- Feeds the downstream motion/navigation sequencer.
- Checks that the path terminates cleanly and ends at the requested end point.

---
 rtl/path_pkg.sv | 26 ++
 rtl/hop_byte_mux.sv | 15 +
 rtl/path_hop_streamer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/path_pkg.sv
// Shared constants, state encoding and byte-extraction helper for the path hop streamer.
// The CPU wrapper imports this package so its SP/EP width stays in step with NODE_W.
package path_pkg;

  localparam int         NUM_WORDS = 9;
  localparam int         NODE_W    = 5;
  localparam logic [7:0] TERM      = 8'hFF;
  localparam int         MAX_HOPS  = 4 * NUM_WORDS;
  localparam int         FLAT_W    = 32 * NUM_WORDS;
  localparam int         IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM,
    DONE
  } state_t;

  // Hop k lives in byte (k mod 4) of word k/4, LSB first. Reads past the last hop return TERM.
  function automatic logic [7:0] byte_at(input logic [FLAT_W-1:0] flat,
                                         input logic [IDX_W-1:0]  k);
    if (int'(k) < MAX_HOPS) return flat[int'(k)*8 +: 8];
    return TERM;
  endfunction

endpackage

// File: rtl/hop_byte_mux.sv
// Selects the current hop byte and its successor from the path snapshot.
// The successor feeds the node_last look-ahead.
module hop_byte_mux
  import path_pkg::*;
(
  input  logic [FLAT_W-1:0] snap,
  input  logic [IDX_W-1:0]  idx,
  output logic [7:0]        cur_byte,
  output logic [7:0]        nxt_byte
);

  assign cur_byte = byte_at(snap, idx);
  assign nxt_byte = byte_at(snap, idx + IDX_W'(1));

endmodule

// File: rtl/path_hop_streamer.sv
// Snapshots the CPU path words on a path_found rising edge and replays them as a
// valid/ready stream of node IDs, flagging malformed paths and a wrong end point.
module path_hop_streamer
  import path_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] ep,
  input  logic              path_found,
  input  logic [FLAT_W-1:0] path_flat,
  output logic [NODE_W-1:0] node_id,
  output logic              node_valid,
  input  logic              node_ready,
  output logic              node_last,
  output logic [5:0]        node_idx,
  output logic              busy,
  output logic              path_done,
  output logic              path_err,
  output logic [5:0]        hop_count
);

  state_t            state, state_next;
  logic              pf_q;
  logic [FLAT_W-1:0] snap;
  logic [NODE_W-1:0] ep_q;
  logic [IDX_W-1:0]  idx;
  logic [5:0]        hop_cnt_q;
  logic              err_q;

  logic [7:0]        cur_byte, nxt_byte;
  logic              start, cur_is_node, at_last;
  logic              hop_fire, err_set;

  hop_byte_mux u_mux (
    .snap     (snap),
    .idx      (idx),
    .cur_byte (cur_byte),
    .nxt_byte (nxt_byte)
  );

  assign start       = path_found & ~pf_q;
  assign cur_is_node = (cur_byte[7:NODE_W] == '0);
  assign at_last     = (idx == IDX_W'(MAX_HOPS - 1)) || (nxt_byte == TERM);

  // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
  always_comb begin
    state_next = state;
    node_valid = 1'b0;
    node_id    = '0;
    node_idx   = '0;
    node_last  = 1'b0;
    busy       = 1'b0;
    path_done  = 1'b0;
    hop_fire   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        // A terminator at idx 0 (empty path) is rejected here along with malformed bytes.
        if (cur_is_node) begin
          state_next = STREAM;
        end else begin
          err_set    = 1'b1;
          state_next = DONE;
        end
      end
      STREAM: begin
        busy       = 1'b1;
        node_valid = 1'b1;
        node_id    = cur_byte[NODE_W-1:0];
        node_idx   = idx;
        node_last  = at_last;
        if (node_ready) begin
          hop_fire   = 1'b1;
          state_next = at_last ? DONE : CHECK;
        end
      end
      DONE: begin
        path_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the snapshot is plain flops, not RAM, so it takes the reset like every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_q      <= 1'b0;
      snap      <= '0;
      ep_q      <= '0;
      idx       <= '0;
      hop_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pf_q <= path_found;
      if (state == IDLE && start) begin
        snap      <= path_flat;
        ep_q      <= ep;
        idx       <= '0;
        hop_cnt_q <= '0;
        err_q     <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
      if (hop_fire) begin
        hop_cnt_q <= hop_cnt_q + 6'd1;
        if (at_last) begin
          if (cur_byte[NODE_W-1:0] != ep_q) err_q <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign hop_count = hop_cnt_q;
  assign path_err  = err_q;

endmodule
